// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pad inputs and the conditioned
// press pulses consumed by the button FIFO writer.
interface button_conditioner_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] buttons_in;
  logic [WIDTH-1:0] buttons_out;
  logic [WIDTH-1:0] stable;

  modport master (
    output buttons_in,
    input  buttons_out,
    input  stable
  );

  modport slave (
    input  buttons_in,
    output buttons_out,
    output stable
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-bit synchronizer, sampled debounce, rising-edge press pulse.
// Optional auto-repeat of held buttons under `BUTTON_REPEAT_EN.
module button_conditioner #(
  parameter int WIDTH          = 3,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int REPEAT_TICKS   = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int TW =
    (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int DW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TW-1:0] T_LAST =
    TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [DW-1:0] D_MAX =
    DW'(PULSE_CNT_MAX);

  if (SAMPLE_CNT_MAX < 1 ||
      PULSE_CNT_MAX < 1 ||
      REPEAT_TICKS < 1) begin : g_bad_cfg
    $error("button_conditioner: counts must be >= 1");
  end

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [DW-1:0]    dcnt [WIDTH];
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] rpt;
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= bus.buttons_in;
      sync <= meta;
    end
  end

  // Shared sample timer; with a period of 1 tick stays high.
  assign tick = (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt[i] <= '0;
      end else if (!sync[i]) begin
        dcnt[i] <= '0;
      end else if (tick && dcnt[i] != D_MAX) begin
        dcnt[i] <= dcnt[i] + DW'(1);
      end
    end

    assign stable_w[i] = (dcnt[i] == D_MAX);
  end

  assign rise = stable_w & ~stable_q;

`ifdef BUTTON_REPEAT_EN
  localparam int RW =
    (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] R_LAST =
    RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rcnt [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_rpt
    assign rpt[i] = stable_w[i] & tick &
                    (rcnt[i] == R_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt[i] <= '0;
      end else if (!stable_w[i]) begin
        rcnt[i] <= '0;
      end else if (rpt[i]) begin
        rcnt[i] <= '0;
      end else if (tick) begin
        rcnt[i] <= rcnt[i] + RW'(1);
      end
    end
  end
`else
  assign rpt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      out_q    <= '0;
    end else begin
      stable_q <= stable_w;
      out_q    <= rise | rpt;
    end
  end

  assign bus.stable      = stable_w;
  assign bus.buttons_out = out_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: cycle model pushes expected {out,stable},
// a negedge monitor pops and compares against the DUT.
module tb_button_conditioner;
  localparam int W = 3;
  localparam int S = 4;
  localparam int P = 3;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if #(.WIDTH(W)) bus();

  button_conditioner #(
    .WIDTH(W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P),
    .REPEAT_TICKS(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int errs = 0;
  logic [5:0] q[$];
  bit [2:0] cur = '0;

  int phase;
  bit [2:0] d1, d2;
  int run[W];
  int rep[W];
  bit [2:0] m_st, m_stq, m_out;

  task automatic check(input string name,
                       input logic [5:0] act,
                       input logic [5:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t: got %b expected %b",
               name, $time, act, exp);
    end
  endtask

  task automatic check_range(input string name,
                             input int v,
                             input int lo,
                             input int hi);
    nvec++;
    if (v < lo || v > hi) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               name, v, lo, hi);
    end
  endtask

  task automatic model_clear();
    phase = 0;
    d1 = '0;
    d2 = '0;
    m_st = '0;
    m_stq = '0;
    m_out = '0;
    for (int i = 0; i < W; i++) begin
      run[i] = 0;
      rep[i] = 0;
    end
  endtask

  // stable = current high run of sync has seen at least P ticks
  task automatic model_step(input bit [2:0] vin);
    bit tk;
    bit [2:0] stp;
    bit [2:0] nout;
    tk = (phase == S - 1);
    stp = m_st;
    nout = m_st & ~m_stq;
    for (int i = 0; i < W; i++) begin
`ifdef BUTTON_REPEAT_EN
      if (!stp[i]) rep[i] = 0;
      else if (tk) begin
        rep[i]++;
        if (rep[i] % R == 0) nout[i] = 1'b1;
      end
`endif
      if (!d2[i]) run[i] = 0;
      else if (tk) run[i]++;
      m_st[i] = (run[i] >= P);
    end
    m_stq = stp;
    m_out = nout;
    d2 = d1;
    d1 = vin;
    phase = (phase + 1) % S;
  endtask

  task automatic step(input bit [2:0] nxt);
    @(posedge clk);
    if (!rst) begin
      model_step(cur);
      q.push_back({m_out, m_st});
    end
    #1;
    bus.buttons_in = nxt;
    cur = nxt;
  endtask

  task automatic hold(input bit [2:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", {bus.buttons_out, bus.stable}, 6'b0);
    q.delete();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0)
      check("cycle", {bus.buttons_out, bus.stable},
            q.pop_front());
  end

  initial begin
    int lat;
    int npulse;
    bit [2:0] nx;
    model_clear();
    bus.buttons_in = '0;
    @(posedge clk);
    #1;
    check("rst_init", {bus.buttons_out, bus.stable}, 6'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset while all buttons are debounced and held
    hold(3'b111, 20);
    do_reset();
    hold(3'b111, 20);
    hold(3'b000, 10);

    // clean press with latency window
    step(3'b001);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step(3'b001);
      if (lat < 0 && bus.buttons_out[0]) lat = k;
    end
    check_range("press_latency", lat, 11, 15);
    hold(3'b001, 20);
    hold(3'b000, 10);

    // bounce on bit 1, then settle high
    for (int k = 0; k < 10; k++)
      hold((k % 2 == 0) ? 3'b010 : 3'b000, 3);
    hold(3'b010, 20);
    hold(3'b000, 10);

    // short press
    hold(3'b100, 6);
    hold(3'b000, 15);

    // simultaneous press
    hold(3'b101, 20);
    hold(3'b000, 10);

    // long hold: one pulse, or repeats every 8 cycles
    npulse = 0;
    for (int k = 0; k < 60; k++) begin
      step(3'b010);
      if (bus.buttons_out[1]) npulse++;
    end
`ifdef BUTTON_REPEAT_EN
    check_range("repeat_count", npulse, 6, 7);
`else
    check_range("single_pulse", npulse, 1, 1);
`endif
    hold(3'b000, 10);

    // randomized slow toggling per bit
    for (int k = 0; k < 600; k++) begin
      nx = cur;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 13) == 0) nx[i] = ~nx[i];
      step(nx);
      if (k == 300) do_reset();
    end
    hold(3'b000, 10);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, errs);
    $finish;
  end
endmodule
